processor_z_core: RTL and testbench

//  Single-cycle-issue Processor Z core: 512x32 instruction RAM, 8x32 register file, fetch/decode/execute.

---
 rtl/processor_z_core.sv | 224 ++++++++++++++++++++++
 tb/tb_processor_z_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_z_core.sv
// rtl/processor_z_core.sv - Processor Z core: 512x32 instruction RAM, 8x32 register file, fetch/decode/execute.
// Optional halt-on-zero-word behaviour is enabled by defining PROCZ_HALT_EN.

module processor_z_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Contents survive reset: program stays resident across reset_n pulses.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

module processor_z_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [3:0]                   rd_a_idx,
    input  logic [3:0]                   rd_b_idx,
    output logic [DATA_W-1:0]            rd_a_data,
    output logic [DATA_W-1:0]            rd_b_data,
    output logic [NREG-1:0][DATA_W-1:0]  regs
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [3:0] NREG_4 = 4'(NREG);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][DATA_W-1:0] regs_d;

    // Indices outside r0..r7 (e.g. 0xF as "no register") read 0 and never write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_idx < NREG_4)) begin
            regs_d[wr_idx[IDX_W-1:0]] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_data = (rd_a_idx < NREG_4) ? regs_q[rd_a_idx[IDX_W-1:0]] : '0;
    assign rd_b_data = (rd_b_idx < NREG_4) ? regs_q[rd_b_idx[IDX_W-1:0]] : '0;
    assign regs      = regs_q;
endmodule

module processor_z_core #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              working,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [15:0]       valC,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] ram_rd_data;
    logic              exec_en;
    logic              wb_hit;
    logic [DATA_W-1:0] wb_data;
    logic              rf_wr_en;
    logic [NREG-1:0][DATA_W-1:0] regs;

`ifdef PROCZ_HALT_EN
    logic ir_valid_q, ir_valid_d;
    logic halted_q, halted_d;
    logic halt_now;
`endif

    processor_z_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr && !working),
        .wr_addr (addr),
        .wr_data (wdata),
        .rd_addr (pc_q),
        .rd_data (ram_rd_data)
    );

    processor_z_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (rf_wr_en),
        .wr_idx    (rB),
        .wr_data   (wb_data),
        .rd_a_idx  (rA),
        .rd_b_idx  (rB),
        .rd_a_data (valA),
        .rd_b_data (valB),
        .regs      (regs)
    );

    assign icode = ir_q[31:28];
    assign ifun  = ir_q[27:24];
    assign rA    = ir_q[23:20];
    assign rB    = ir_q[19:16];
    assign valC  = ir_q[15:0];

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

    // Writeback value for the instruction currently held in IR.
    always_comb begin
        wb_hit  = 1'b0;
        wb_data = '0;
        if (ir_q[31:24] == 8'h10) begin
            wb_hit  = 1'b1;
            wb_data = {{(DATA_W-16){1'b0}}, valC};
        end else if (icode == 4'h2) begin
            wb_hit = (ifun < 4'h4);
            case (ifun)
                4'h0:    wb_data = valB + valA;
                4'h1:    wb_data = valB - valA;
                4'h2:    wb_data = valB & valA;
                4'h3:    wb_data = valB ^ valA;
                default: wb_data = '0;
            endcase
        end
    end

`ifdef PROCZ_HALT_EN
    // A zero word only halts once it was really fetched; the reset/load IR of 0 does not.
    always_comb begin
        halt_now = working && (halted_q || (ir_valid_q && (ir_q == 32'h0)));
        halted_d = halt_now;
        exec_en  = working && !halt_now;
    end
`else
    always_comb begin
        exec_en = working;
    end
`endif

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_wr_en = exec_en && wb_hit;
`ifdef PROCZ_HALT_EN
        ir_valid_d = ir_valid_q;
`endif
        if (!working) begin
            ir_d = '0;
`ifdef PROCZ_HALT_EN
            ir_valid_d = 1'b0;
`endif
        end else if (exec_en) begin
            ir_d = ram_rd_data[31:0];
            pc_d = pc_q + 1'b1;
`ifdef PROCZ_HALT_EN
            ir_valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
            ir_q <= '0;
`ifdef PROCZ_HALT_EN
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
`ifdef PROCZ_HALT_EN
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
`endif
        end
    end
endmodule

// File: tb/tb_processor_z_core.sv
// tb/tb_processor_z_core.sv - scoreboard bench for processor_z_core (default build).

module tb_processor_z_core;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  icode, ifun, rA, rB;
    logic [15:0] valC;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7, valA, valB;

    processor_z_core dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .working (working),
        .icode   (icode),
        .ifun    (ifun),
        .rA      (rA),
        .rB      (rB),
        .valC    (valC),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .valA    (valA),
        .valB    (valB)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]  ir;
        logic [255:0] regs;
        logic [31:0]  va;
        logic [31:0]  vb;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [512];
    logic [31:0] m_regs [8];
    logic [8:0]  m_pc;
    logic [31:0] m_ir;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] dut_regs [8];

    assign dut_regs[0] = r0;
    assign dut_regs[1] = r1;
    assign dut_regs[2] = r2;
    assign dut_regs[3] = r3;
    assign dut_regs[4] = r4;
    assign dut_regs[5] = r5;
    assign dut_regs[6] = r6;
    assign dut_regs[7] = r7;

    function automatic logic [31:0] m_rd(input logic [3:0] i);
        return (i < 4'd8) ? m_regs[i[2:0]] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_ir = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
    endtask

    task automatic model_edge(input logic w, input logic wr_i, input logic [8:0] a, input logic [31:0] d);
        logic        en;
        logic [31:0] val, va, vb;
        logic [3:0]  rb;
        if (w) begin
            en  = 1'b0;
            val = '0;
            rb  = m_ir[19:16];
            va  = m_rd(m_ir[23:20]);
            vb  = m_rd(rb);
            if (m_ir[31:24] == 8'h10) begin
                en  = 1'b1;
                val = {16'h0, m_ir[15:0]};
            end else if (m_ir[31:28] == 4'h2) begin
                en = 1'b1;
                case (m_ir[27:24])
                    4'h0:    val = vb + va;
                    4'h1:    val = vb - va;
                    4'h2:    val = vb & va;
                    4'h3:    val = vb ^ va;
                    default: en = 1'b0;
                endcase
            end
            if (en && rb < 4'd8) m_regs[rb[2:0]] = val;
            m_ir = m_mem[m_pc];
            m_pc = m_pc + 9'd1;
        end else begin
            if (wr_i) m_mem[a] = d;
            m_ir = '0;
        end
    endtask

    // One clock edge: predict, push, clock, pop and compare.
    task automatic step(input logic w, input logic wr_i, input logic [8:0] a, input logic [31:0] d);
        exp_t e;
        working = w;
        wr      = wr_i;
        addr    = a;
        wdata   = d;
        model_edge(w, wr_i, a, d);
        e.ir = m_ir;
        for (int i = 0; i < 8; i++) e.regs[i*32 +: 32] = m_regs[i];
        e.va = m_rd(m_ir[23:20]);
        e.vb = m_rd(m_ir[19:16]);
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({icode, ifun, rA, rB, valC} !== e.ir) begin
            errors++;
            $display("FAIL sb_decode: got %h expected %h", {icode, ifun, rA, rB, valC}, e.ir);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_regs[i] !== e.regs[i*32 +: 32]) begin
                errors++;
                $display("FAIL sb_r%0d: got %h expected %h", i, dut_regs[i], e.regs[i*32 +: 32]);
            end
        end
        checks++;
        if (valA !== e.va || valB !== e.vb) begin
            errors++;
            $display("FAIL sb_valab: got %h/%h expected %h/%h", valA, valB, e.va, e.vb);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        working = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({icode, ifun, rA, rB, valC} !== 32'h0 || {r0, r1, r2, r3, r4, r5, r6, r7} !== 256'h0) begin
            errors++;
            $display("FAIL reset_state: decode %h r0 %h expected all zero", {icode, ifun, rA, rB, valC}, r0);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] prog [12];
        prog = '{32'h10F00080, 32'h10F10081, 32'h10F20082, 32'h10F30083,
                 32'h10F40084, 32'h10F50085, 32'h10F60086, 32'h10F70087,
                 32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000};
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 9'(i), (i < 12) ? prog[i] : 32'h0);
        step(1'b1, 1'b0, 9'h0, 32'h0);
        checks++;
        if (icode !== 4'h1 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'h0 || valC !== 16'h0080) begin
            errors++;
            $display("FAIL first_decode: got %h expected 10f00080", {icode, ifun, rA, rB, valC});
        end
    endtask

    task automatic test_irmovl();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 9'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_regs[i] !== 32'h80 + 32'(i)) begin
                errors++;
                $display("FAIL irmovl_r%0d: got %h expected %h", i, dut_regs[i], 32'h80 + 32'(i));
            end
        end
    endtask

    task automatic test_opl();
        logic [31:0] want [8];
        want = '{32'h80, 32'h101, 32'h82, 32'h1, 32'h84, 32'h84, 32'h86, 32'h1};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_regs[i] !== want[i]) begin
                errors++;
                $display("FAIL opl_r%0d: got %h expected %h", i, dut_regs[i], want[i]);
            end
        end
    endtask

    task automatic test_pause();
        step(1'b0, 1'b0, 9'h0, 32'h0);
        step(1'b0, 1'b0, 9'h0, 32'h0);
        checks++;
        if ({icode, ifun, rA, rB, valC} !== 32'h0 || r1 !== 32'h101) begin
            errors++;
            $display("FAIL pause_hold: decode %h r1 %h expected 0 and 101", {icode, ifun, rA, rB, valC}, r1);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 9'h0, 32'h0);
    endtask

    task automatic test_guard_wrap();
        int n = 0;
        while (m_pc != 9'd1 && n < 600) begin
            step(1'b1, 1'b1, 9'h0, 32'h10F000AA);
            n++;
        end
        checks++;
        if (n >= 600 || {icode, ifun, rA, rB, valC} !== 32'h10F00080) begin
            errors++;
            $display("FAIL wrap_refetch: got %h after %0d edges expected 10f00080", {icode, ifun, rA, rB, valC}, n);
        end
        step(1'b1, 1'b0, 9'h0, 32'h0);
        checks++;
        if (r0 !== 32'h80) begin
            errors++;
            $display("FAIL guard_r0: got %h expected 00000080", r0);
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 9'h0, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({icode, ifun, rA, rB, valC} !== 32'h0 || {r0, r1, r2, r3, r4, r5, r6, r7} !== 256'h0) begin
            errors++;
            $display("FAIL midrun_reset: decode %h r1 %h expected all zero", {icode, ifun, rA, rB, valC}, r1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 9'h0, 32'h0);
        checks++;
        if (r1 !== 32'h101 || r3 !== 32'h1 || r5 !== 32'h84 || r7 !== 32'h1) begin
            errors++;
            $display("FAIL ram_kept: r1 %h r3 %h r5 %h r7 %h expected 101 1 84 1", r1, r3, r5, r7);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_irmovl();
        test_opl();
        test_pause();
        test_guard_wrap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
